// File: rtl/truth_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_pkg
// Brief    : Shared types and defaults for the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_pkg;

  localparam int c_n_in_default          = 3;
  localparam int c_settle_cycles_default = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int tbl_width(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2gray.sv
`default_nettype none
// ============================================================================
// Module   : bin2gray
// Brief    : Combinational binary to reflected-Gray converter.
// Revision : 1.0 - initial release
// ============================================================================
module bin2gray #(
  parameter int N = 3
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Walks every input vector of a small combinational block, captures
//            its output into a truth table and compares against a golden one.
//            Define SWEEP_GRAY_EN to step vectors in reflected-Gray order.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_IN          = c_n_in_default,
  parameter int SETTLE_CYCLES = c_settle_cycles_default
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       y_in,
  input  logic [tbl_width(N_IN)-1:0] expected,
  output logic [N_IN-1:0]            vec_out,
  output logic                       busy,
  output logic                       done,
  output logic [tbl_width(N_IN)-1:0] table_out,
  output logic                       pass,
  output logic [N_IN:0]              mismatch_count,
  output logic                       fail_valid,
  output logic [N_IN-1:0]            first_fail_idx
);

  localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0]         c_s_idle      = IDLE;
  localparam logic [1:0]         c_s_drive     = DRIVE;
  localparam logic [1:0]         c_s_sample    = SAMPLE;
  localparam logic [1:0]         c_s_done      = DONE;
  localparam logic [N_IN-1:0]    c_last_idx    = '1;
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);

  logic [1:0]                 r_state;
  logic [N_IN-1:0]            r_idx;
  logic [c_cnt_w-1:0]         r_cnt;
  logic [tbl_width(N_IN)-1:0] r_table;
  logic [N_IN:0]              r_mcnt;
  logic                       r_fail_valid;
  logic [N_IN-1:0]            r_first;
  logic                       r_pass;

  logic [N_IN-1:0] w_vec;
  logic            w_bad;
  logic [N_IN:0]   w_mcnt_next;

`ifdef SWEEP_GRAY_EN
  bin2gray #(
    .N(N_IN)
  ) u_bin2gray (
    .bin  (r_idx),
    .gray (w_vec)
  );
`else
  assign w_vec = r_idx;
`endif

  // Results are indexed by the vector value, not by sweep step.
  assign w_bad       = (y_in != expected[w_vec]);
  assign w_mcnt_next = r_mcnt + (N_IN+1)'(w_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_s_idle;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_table      <= '0;
      r_mcnt       <= '0;
      r_fail_valid <= 1'b0;
      r_first      <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        c_s_idle: begin
          if (start && !abort) begin
            r_state      <= c_s_drive;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_table      <= '0;
            r_mcnt       <= '0;
            r_fail_valid <= 1'b0;
            r_first      <= '0;
            r_pass       <= 1'b0;
          end
        end
        c_s_drive: begin
          if (abort) begin
            r_state <= c_s_idle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_settle_last) r_state <= c_s_sample;
          end
        end
        c_s_sample: begin
          if (abort) begin
            r_state <= c_s_idle;
          end else begin
            r_table[w_vec] <= y_in;
            if (w_bad) begin
              r_mcnt <= w_mcnt_next;
              if (!r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_first      <= w_vec;
              end
            end
            // pass must be visible in the DONE cycle, so use the updated count.
            if (r_idx == c_last_idx) begin
              r_state <= c_s_done;
              r_pass  <= (w_mcnt_next == '0);
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= '0;
              r_state <= c_s_drive;
            end
          end
        end
        c_s_done: r_state <= c_s_idle;
        default:  r_state <= c_s_idle;
      endcase
    end
  end

  assign busy           = (r_state != c_s_idle);
  assign done           = (r_state == c_s_done);
  assign vec_out        = busy ? w_vec : '0;
  assign table_out      = r_table;
  assign pass           = r_pass;
  assign mismatch_count = r_mcnt;
  assign fail_valid     = r_fail_valid;
  assign first_fail_idx = r_first;

endmodule
`default_nettype wire
